// File: rtl/dm_responder.sv
// Purpose : data-memory responder for the MIPS core data port, with a hardware
//           zero-clear after reset and an optional store-trace FIFO (DM_TRACE_EN).
// Latency : reads are combinational; writes commit at posedge; a trace entry is
//           visible on trace_* the cycle after its write edge.
// Backpressure: the core is never stalled except by busy during the clear; when the
//           trace FIFO is full and not popping, the trace entry is dropped
//           (trace_overflow sticks) while the memory write still commits.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   m_data_addr/wdata     byte address / lane-aligned store data from the core
//   m_data_byteen         per-lane write enable (0 = no write)
//   m_inst_addr           PC of the storing instruction (trace only)
//   m_data_rdata          combinational read word, 0 while busy
//   busy                  high while the clear sequencer runs
//   trace_valid/ready     ready/valid head of the store trace FIFO
//   trace_pc/addr/data    head entry: PC, word-aligned address, merged word
//   trace_overflow        sticky, a trace push was dropped
//
// Build option: define DM_TRACE_EN to include the trace FIFO; otherwise the
// trace outputs are tied to 0 and trace_ready is ignored.

// Generic FIFO: registered storage, show-ahead head.
// Latency : one cycle from push edge to out_vld.
// Backpressure: in_rdy drops when full unless the head is popped in the same cycle.
module dm_fifo #(
  parameter int WIDTH     = 96,
  parameter int LOG_DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0] FULL_CNT = {1'b1, {LOG_DEPTH{1'b0}}};

  logic [WIDTH-1:0]     ram [0:DEPTH-1];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign out_vld = (count != '0);
  assign out_dat = ram[rd_ptr];
  assign do_pop  = out_vld && out_rdy;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign in_rdy  = (count != FULL_CNT) || do_pop;
  assign do_push = in_vld && in_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (do_push) ram[wr_ptr] <= in_dat;
  end
endmodule

module dm_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int LOG_DEPTH  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        busy,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_overflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [31:0]           mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           old_word;
  logic [31:0]           merged;
  logic                  wr_commit;

  assign word_idx = m_data_addr[ADDR_WIDTH+1:2];
  assign old_word = mem[word_idx];

  // ---------------- clear sequencer ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy = 1'b1;
        // Last word is cleared on this edge, so READY starts right after it.
        if (&clr_cnt) state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 clr_cnt <= '0;
    else if (state_q == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  // ---------------- memory array ----------------
  assign wr_commit = (state_q == ST_READY) && (m_data_byteen != 4'b0000);

  always_comb begin
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (m_data_byteen[k]) merged[8*k +: 8] = m_data_wdata[8*k +: 8];
    end
  end

  // Single write port shared by the clear sequencer and core stores; they are
  // mutually exclusive because stores are ignored while busy.
  always_ff @(posedge clk) begin
    if (busy)           mem[clr_cnt]  <= '0;
    else if (wr_commit) mem[word_idx] <= merged;
  end

  // Read sees the pre-write word in the cycle of a store to the same address.
  assign m_data_rdata = busy ? 32'h0 : old_word;

  // ---------------- store trace ----------------
`ifdef DM_TRACE_EN
  logic        push_rdy;
  logic        head_vld;
  logic [95:0] head_dat;
  logic        overflow_q;
  logic        unused_addr_lsb;

  dm_fifo #(
    .WIDTH     (96),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_trace_fifo (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (wr_commit),
    .in_rdy  (push_rdy),
    .in_dat  ({m_inst_addr, m_data_addr[31:2], 2'b00, merged}),
    .out_vld (head_vld),
    .out_rdy (trace_ready),
    .out_dat (head_dat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       overflow_q <= 1'b0;
    else if (wr_commit && !push_rdy)  overflow_q <= 1'b1;
  end

  // Head fields are masked while empty so idle outputs read as zero.
  assign trace_valid     = head_vld;
  assign trace_pc        = head_vld ? head_dat[95:64] : 32'h0;
  assign trace_addr      = head_vld ? head_dat[63:32] : 32'h0;
  assign trace_data      = head_vld ? head_dat[31:0]  : 32'h0;
  assign trace_overflow  = overflow_q;
  assign unused_addr_lsb = ^m_data_addr[1:0];
`else
  logic unused_trace;

  assign trace_valid    = 1'b0;
  assign trace_pc       = 32'h0;
  assign trace_addr     = 32'h0;
  assign trace_data     = 32'h0;
  assign trace_overflow = 1'b0;
  assign unused_trace   = ^{trace_ready, m_inst_addr, m_data_addr[31:ADDR_WIDTH+2],
                            m_data_addr[1:0]};
`endif
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: clear sequencing, byte-lane merges,
// read-during-write ordering, trace FIFO order, full and overflow handling.
// Trace expectations collapse to 0 when DM_TRACE_EN is not defined.
module tb_dm_responder;
`ifdef DM_TRACE_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        busy;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;

  int vec_cnt = 0;
  int err_cnt = 0;
  int n;

  dm_responder #(.ADDR_WIDTH(12), .LOG_DEPTH(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .m_data_addr    (m_data_addr),
    .m_data_wdata   (m_data_wdata),
    .m_data_byteen  (m_data_byteen),
    .m_inst_addr    (m_inst_addr),
    .m_data_rdata   (m_data_rdata),
    .busy           (busy),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_pc       (trace_pc),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc,
                          input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_vld"},  {31'b0, trace_valid}, {31'b0, TEN});
    chk({tag, "_pc"},   trace_pc,   TEN ? pc   : 32'h0);
    chk({tag, "_addr"}, trace_addr, TEN ? addr : 32'h0);
    chk({tag, "_data"}, trace_data, TEN ? data : 32'h0);
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    m_inst_addr   = pc;
    m_data_addr   = addr;
    m_data_wdata  = data;
    m_data_byteen = be;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    trace_ready = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 4'b0000);
    repeat (5) tick();
    chk("rst_busy",   {31'b0, busy},           32'd1);
    chk("rst_tvld",   {31'b0, trace_valid},    32'd0);
    chk("rst_ovf",    {31'b0, trace_overflow}, 32'd0);
    chk("rst_rdata",  m_data_rdata,            32'h0);
    chk("rst_tpc",    trace_pc,                32'h0);

    // Abort a clear part way through; the restart must be a full sweep.
    reset = 1'b1;
    repeat (100) tick();
    chk("clr100_busy", {31'b0, busy}, 32'd1);
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;

    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      if (n == 10) drive(32'h2000, 32'h0, 32'hFFFF_FFFF, 4'b1111);
      if (n == 11) drive(32'h0, 32'h10, 32'h0, 4'b0000);
      if (n == 100) begin
        chk("clr_rdata", m_data_rdata, 32'h0);
        chk("clr_tvld",  {31'b0, trace_valid}, 32'd0);
      end
      tick();
    end
    chk("busy_len",  n, 32'd4096);
    chk("post_busy", {31'b0, busy}, 32'd0);
    chk("post_rd10", m_data_rdata, 32'h0);
    m_data_addr = 32'h0;
    #1;
    chk("ign_wr",    m_data_rdata, 32'h0);
    chk("ign_tvld",  {31'b0, trace_valid}, 32'd0);

    // Full-word store, then two partial-lane merges into the same word.
    drive(32'h3004, 32'h10, 32'h1234_5678, 4'b1111);
    #1;
    chk("wr1_same_cyc", m_data_rdata, 32'h0);
    tick();
    m_data_byteen = 4'b0000;
    chk("wr1_rd", m_data_rdata, 32'h1234_5678);
    chk_head("wr1_head", 32'h3004, 32'h10, 32'h1234_5678);

    drive(32'h3008, 32'h11, 32'h0000_AB00, 4'b0010);
    tick();
    m_data_byteen = 4'b0000;
    chk("wr2_rd", m_data_rdata, 32'h1234_AB78);
    chk_head("wr1_hold", 32'h3004, 32'h10, 32'h1234_5678);

    drive(32'h300C, 32'h12, 32'hCDEF_0000, 4'b1100);
    tick();
    m_data_byteen = 4'b0000;
    chk("wr3_rd", m_data_rdata, 32'hCDEF_AB78);

    trace_ready = 1'b1;
    chk_head("d0", 32'h3004, 32'h10, 32'h1234_5678);
    tick();
    chk_head("d1", 32'h3008, 32'h10, 32'h1234_AB78);
    tick();
    chk_head("d2", 32'h300C, 32'h10, 32'hCDEF_AB78);
    tick();
    chk("d_empty", {31'b0, trace_valid}, 32'd0);
    trace_ready = 1'b0;

    // Fill all 8 entries with no consumer.
    for (int i = 0; i < 8; i++) begin
      drive(32'h4000 + 32'(4*i), 32'h100 + 32'(4*i), 32'(i+1) * 32'h1111_1111, 4'b1111);
      tick();
    end
    m_data_byteen = 4'b0000;
    chk("full_ovf", {31'b0, trace_overflow}, 32'd0);
    chk_head("full_head", 32'h4000, 32'h100, 32'h1111_1111);

    // Push with simultaneous pop while full: accepted, no overflow.
    trace_ready = 1'b1;
    drive(32'h5000, 32'h200, 32'hA5A5_A5A5, 4'b1111);
    tick();
    trace_ready   = 1'b0;
    m_data_byteen = 4'b0000;
    chk("pp_ovf", {31'b0, trace_overflow}, 32'd0);
    chk_head("pp_head", 32'h4004, 32'h104, 32'h2222_2222);

    // Push with no pop while full: dropped from trace, memory still written.
    drive(32'h6000, 32'h300, 32'hDEAD_BEEF, 4'b1111);
    tick();
    m_data_byteen = 4'b0000;
    chk("drop_ovf", {31'b0, trace_overflow}, {31'b0, TEN});
    chk("drop_mem", m_data_rdata, 32'hDEAD_BEEF);

    trace_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk_head($sformatf("dr%0d", i), 32'h4000 + 32'(4*i), 32'h100 + 32'(4*i),
               32'(i+1) * 32'h1111_1111);
      tick();
    end
    chk_head("dr8", 32'h5000, 32'h200, 32'hA5A5_A5A5);
    tick();
    chk("dr_empty",  {31'b0, trace_valid},    32'd0);
    chk("dr_ovf",    {31'b0, trace_overflow}, {31'b0, TEN});
    m_data_addr = 32'h104;
    #1;
    chk("mem_104", m_data_rdata, 32'h2222_2222);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
